// File: rtl/psw_flag_unit.sv
// Processor-status-word unit: N/Z/V/C flag register, LIFO save/restore stack and branch-condition decode.
// Define PSW_COND_EN to enable the cond_sel decoder; otherwise cond_true is tied low.
module psw_flag_unit #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [2:0]       op_class,
   input  logic [WIDTH-1:0] result,
   input  logic             src_msb,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             shifter_cf,
   input  logic             wr_en,
   input  logic [3:0]       wr_data,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   input  logic [3:0]       cond_sel,
   output logic [3:0]       flags,
   output logic             cond_true,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);
   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_ARITH = 3'd1,
      OP_LOGIC = 3'd2,
      OP_ASL   = 3'd3,
      OP_SHIFT = 3'd4,
      OP_MOVE  = 3'd5,
      OP_CLR   = 3'd6,
      OP_RSVD  = 3'd7
   } op_class_e;

   logic [3:0]    flags_q, flags_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [3:0]    entry_q [STACK_DEPTH];
   logic [3:0]    top_entry;
   logic [3:0]    ex_flags;
   logic          msb, zero;
   logic          full, empty;
   logic          push_ok, pop_ok, stack_misuse;

   assign msb   = result[WIDTH-1];
   assign zero  = (result == '0);
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Any collision or over/underflow leaves the stack untouched and only raises the error.
   assign push_ok      = push & ~pop & ~full;
   assign pop_ok       = pop & ~push & ~empty;
   assign stack_misuse = (push & pop) | (push & full) | (pop & empty);

   always_comb begin
      ex_flags = flags_q;
      case (op_class_e'(op_class))
         OP_ARITH: ex_flags = {msb, zero, alu_overflow, alu_carry};
         OP_LOGIC: ex_flags = {msb, zero, 1'b0, 1'b0};
         OP_ASL:   ex_flags = {msb, zero, src_msb ^ msb, shifter_cf};
         OP_SHIFT: ex_flags = {msb, zero, 1'b0, shifter_cf};
         OP_MOVE:  ex_flags = {msb, zero, flags_q[1:0]};
         OP_CLR:   ex_flags = 4'b0100;
         default:  ex_flags = flags_q;
      endcase
   end

   always_comb begin
      top_entry = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (count_q == CW'(i + 1)) top_entry = entry_q[i];
      end
   end

   always_comb begin
      flags_d = flags_q;
      if (pop_ok)        flags_d = top_entry;
      else if (wr_en)    flags_d = wr_data;
      else if (ex_valid) flags_d = ex_flags;

      count_d = count_q;
      if (push_ok)     count_d = count_q + 1'b1;
      else if (pop_ok) count_d = count_q - 1'b1;

      err_d = err_q;
      if (stack_misuse) err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Entries carry no reset; clearing count is enough to discard them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (push_ok && count_q == CW'(i)) entry_q[i] <= flags_q;
      end
   end

`ifdef PSW_COND_EN
   logic n_f, z_f, v_f, c_f;
   assign {n_f, z_f, v_f, c_f} = flags_q;

   always_comb begin
      cond_true = 1'b0;
      case (cond_sel)
         4'd0:  cond_true = 1'b1;
         4'd1:  cond_true = z_f;
         4'd2:  cond_true = ~z_f;
         4'd3:  cond_true = n_f;
         4'd4:  cond_true = ~n_f;
         4'd5:  cond_true = v_f;
         4'd6:  cond_true = ~v_f;
         4'd7:  cond_true = c_f;
         4'd8:  cond_true = ~c_f;
         4'd9:  cond_true = ~(n_f ^ v_f);
         4'd10: cond_true = n_f ^ v_f;
         4'd11: cond_true = ~z_f & ~(n_f ^ v_f);
         4'd12: cond_true = z_f | (n_f ^ v_f);
         4'd13: cond_true = ~c_f & ~z_f;
         4'd14: cond_true = c_f | z_f;
         default: cond_true = 1'b0;
      endcase
   end
`else
   logic unused_cond_sel;
   assign unused_cond_sel = ^cond_sel;
   assign cond_true       = 1'b0;
`endif

   assign flags       = flags_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign stack_err   = err_q;
endmodule
